// File: rtl/dma_apb_master_arb.sv
// Round-robin arbiter and APB master sequencer for the DMA control path.
// Single-beat requests are granted in turn and run through SETUP/ACCESS.
module dma_apb_master_arb #(
  parameter int NUM_REQ        = 2,
  parameter int APB_SVL        = 4,
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 16,
  parameter int TIMEOUT        = 16
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic [NUM_REQ-1:0]                       i_req_valid,
  input  logic [NUM_REQ-1:0]                       i_req_write,
  input  logic [NUM_REQ*$clog2(APB_SVL)-1:0]       i_req_slv,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]        i_req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]        i_req_wdata,
  output logic [NUM_REQ-1:0]                       o_req_ready,
  output logic [NUM_REQ-1:0]                       o_rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]                o_rsp_rdata,
  output logic                                     o_rsp_err,
  output logic [$clog2(APB_SVL)-1:0]               o_psel_idx,
  output logic                                     o_psel_vld,
  output logic                                     o_penable,
  output logic                                     o_pwrite,
  output logic [APB_ADDR_WIDTH-1:0]                o_paddr,
  output logic [APB_DATA_WIDTH-1:0]                o_pwdata,
  input  logic                                     i_pready,
  input  logic [APB_DATA_WIDTH-1:0]                i_prdata
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = $clog2(APB_SVL);
  localparam int CW = $clog2(TIMEOUT);
  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   rr, rr_n, win, id;
  logic            hit, take;
  logic            wr;
  logic [SW-1:0]   slv;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [CW-1:0]   cnt, cnt_n;
  logic            slv_bad;
  logic [NUM_REQ-1:0] ready_n, rsp_valid_n;
  logic [DW-1:0]   rdata_n;
  logic            err_n, psel_vld_n, penable_n;

  assign slv_bad = {{(32-SW){1'b0}}, slv} >= 32'(APB_SVL);

  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!hit && i_req_valid[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

  // A grant shows as o_req_ready while still in IDLE; the next edge
  // then launches SETUP, so ready doubles as the "accepted" marker.
  always_comb begin
    state_n     = state;
    rr_n        = rr;
    cnt_n       = cnt;
    take        = 1'b0;
    ready_n     = '0;
    rsp_valid_n = '0;
    rdata_n     = '0;
    err_n       = 1'b0;
    psel_vld_n  = 1'b0;
    penable_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|o_req_ready) begin
          if (slv_bad) begin
            state_n         = RESP;
            rsp_valid_n[id] = 1'b1;
            err_n           = 1'b1;
          end else begin
            state_n    = SETUP;
            psel_vld_n = 1'b1;
            cnt_n      = '0;
          end
        end else if (hit) begin
          take = 1'b1;
        end
      end
      SETUP: begin
        state_n    = ACCESS;
        psel_vld_n = 1'b1;
        penable_n  = 1'b1;
        cnt_n      = '0;
      end
      ACCESS: begin
        if (i_pready) begin
          state_n         = RESP;
          rsp_valid_n[id] = 1'b1;
          rdata_n         = wr ? '0 : i_prdata;
        end else if (cnt == CW'(TIMEOUT-1)) begin
          state_n         = RESP;
          rsp_valid_n[id] = 1'b1;
          err_n           = 1'b1;
        end else begin
          psel_vld_n = 1'b1;
          penable_n  = 1'b1;
          cnt_n      = cnt + 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        take    = hit;
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      ready_n[win] = 1'b1;
      rr_n = (win == IW'(NUM_REQ-1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rr          <= '0;
      cnt         <= '0;
      id          <= '0;
      wr          <= 1'b0;
      slv         <= '0;
      addr        <= '0;
      wdata       <= '0;
      o_req_ready <= '0;
      o_rsp_valid <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
      o_psel_idx  <= '0;
      o_psel_vld  <= 1'b0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
    end else begin
      state       <= state_n;
      rr          <= rr_n;
      cnt         <= cnt_n;
      if (take) begin
        id    <= win;
        wr    <= i_req_write[win];
        slv   <= i_req_slv[win*SW +: SW];
        addr  <= i_req_addr[win*AW +: AW];
        wdata <= i_req_wdata[win*DW +: DW];
      end
      o_req_ready <= ready_n;
      o_rsp_valid <= rsp_valid_n;
      o_rsp_rdata <= rdata_n;
      o_rsp_err   <= err_n;
      o_psel_vld  <= psel_vld_n;
      o_penable   <= penable_n;
      o_psel_idx  <= psel_vld_n ? slv : '0;
      o_pwrite    <= psel_vld_n & wr;
      o_paddr     <= psel_vld_n ? addr : '0;
      o_pwdata    <= psel_vld_n ? wdata : '0;
    end
  end

endmodule

// File: tb/tb_dma_apb_master_arb.sv
// Directed bench for dma_apb_master_arb: grant timing, waits,
// round-robin order, timeout and reset abandonment.
module tb_dma_apb_master_arb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [3:0]  req_slv;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  psel_idx;
  logic        psel_vld;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic        pready;
  logic [15:0] prdata;

  int n_chk = 0;
  int n_err = 0;

  dma_apb_master_arb dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_write (req_write),
    .i_req_slv   (req_slv),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_psel_idx  (psel_idx),
    .o_psel_vld  (psel_vld),
    .o_penable   (penable),
    .o_pwrite    (pwrite),
    .o_paddr     (paddr),
    .o_pwdata    (pwdata),
    .i_pready    (pready),
    .i_prdata    (prdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_out();
    return {6'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, psel_idx,
            psel_vld, penable, pwrite, paddr, pwdata};
  endfunction

  task automatic set_req(input int r, input logic wr, input logic [1:0] s,
                         input logic [15:0] a, input logic [15:0] d);
    req_write[r]        = wr;
    req_slv[r*2 +: 2]   = s;
    req_addr[r*16 +: 16]  = a;
    req_wdata[r*16 +: 16] = d;
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req_ready != 2'b00) break;
    end
    chk(tag, req_ready, exp);
    req_valid = req_valid & ~req_ready;
  endtask

  logic [1:0] grants [4];
  int gaps [4];
  int acc, viol, g, last, bad;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_slv = '0;
    req_addr = '0; req_wdata = '0;
    pready = 1'b0; prdata = '0;
    tick(); tick();
    chk("reset_outs", all_out(), 64'd0);
    rst_n = 1'b1;
    tick();

    // read, zero-wait slave
    set_req(0, 1'b0, 2'd2, 16'h0010, 16'h0000);
    req_valid = 2'b01;
    wait_grant("t1_grant", 2'b01);
    chk("t1_T_psel", psel_vld, 1'b0);
    tick();
    chk("t1_setup_psel", psel_vld, 1'b1);
    chk("t1_setup_pen", penable, 1'b0);
    chk("t1_setup_idx", psel_idx, 2'd2);
    chk("t1_setup_addr", paddr, 16'h0010);
    chk("t1_setup_ready", req_ready, 2'b00);
    pready = 1'b1; prdata = 16'hBEEF;
    tick();
    chk("t1_acc_psel", psel_vld, 1'b1);
    chk("t1_acc_pen", penable, 1'b1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_rdata", rsp_rdata, 16'hBEEF);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rsp_psel", psel_vld, 1'b0);
    pready = 1'b0;
    tick();
    chk("t1_idle_rsp", rsp_valid, 2'b00);

    // write with 3 wait states
    set_req(1, 1'b1, 2'd1, 16'h0004, 16'h1234);
    req_valid = 2'b10;
    wait_grant("t2_grant", 2'b10);
    prdata = 16'hFFFF;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_acc_pen", penable, 1'b1);
      chk("t2_acc_addr", paddr, 16'h0004);
      chk("t2_acc_wdata", pwdata, 16'h1234);
      chk("t2_acc_write", pwrite, 1'b1);
      chk("t2_acc_idx", psel_idx, 2'd1);
      if (i == 3) pready = 1'b1;
    end
    tick();
    chk("t2_rsp_valid", rsp_valid, 2'b10);
    chk("t2_rsp_err", rsp_err, 1'b0);
    chk("t2_rsp_rdata", rsp_rdata, 16'h0000);
    pready = 1'b0;
    tick();

    // both requesters continuously valid, zero-wait slave
    set_req(0, 1'b0, 2'd0, 16'h0100, 16'h0000);
    set_req(1, 1'b0, 2'd3, 16'h0200, 16'h0000);
    pready = 1'b1; prdata = 16'h0F0F;
    req_valid = 2'b11;
    g = 0; last = 0; viol = 0;
    for (int c = 0; c < 60 && g < 4; c++) begin
      tick();
      if (!$onehot0(req_ready) || !$onehot0(rsp_valid) ||
          (penable && !psel_vld)) viol++;
      if (req_ready != 2'b00) begin
        grants[g] = req_ready;
        gaps[g] = c - last;
        last = c;
        g++;
        if (g == 4) req_valid = 2'b00;
      end
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (!$onehot0(rsp_valid) || (penable && !psel_vld)) viol++;
    end
    chk("t3_grant0", grants[0], 2'b01);
    chk("t3_grant1", grants[1], 2'b10);
    chk("t3_grant2", grants[2], 2'b01);
    chk("t3_grant3", grants[3], 2'b10);
    chk("t3_gap1", gaps[1], 4);
    chk("t3_gap3", gaps[3], 4);
    chk("t3_onehot", viol, 0);
    pready = 1'b0;
    tick();

    // slave never ready: timeout
    set_req(0, 1'b0, 2'd3, 16'h0020, 16'h0000);
    req_valid = 2'b01;
    prdata = 16'h7777;
    wait_grant("t4_grant", 2'b01);
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (penable) acc++;
      if (rsp_valid != 2'b00) break;
    end
    chk("t4_access_cycles", acc, 16);
    chk("t4_rsp_valid", rsp_valid, 2'b01);
    chk("t4_rsp_err", rsp_err, 1'b1);
    chk("t4_rsp_rdata", rsp_rdata, 16'h0000);
    tick();
    chk("t4_idle_psel", psel_vld, 1'b0);
    chk("t4_idle_rsp", rsp_valid, 2'b00);

    // pready on the timeout cycle wins
    set_req(1, 1'b0, 2'd2, 16'h0030, 16'h0000);
    req_valid = 2'b10;
    wait_grant("t5_grant", 2'b10);
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (penable) acc++;
      if (acc == 16 && penable) begin
        pready = 1'b1; prdata = 16'h5A5A;
      end
      if (rsp_valid != 2'b00) break;
    end
    chk("t5_rsp_valid", rsp_valid, 2'b10);
    chk("t5_rsp_err", rsp_err, 1'b0);
    chk("t5_rsp_rdata", rsp_rdata, 16'h5A5A);
    pready = 1'b0;
    tick();

    // reset during ACCESS
    set_req(0, 1'b0, 2'd1, 16'h0040, 16'h0000);
    req_valid = 2'b01;
    wait_grant("t6_grant", 2'b01);
    tick();
    tick();
    chk("t6_in_access", penable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", all_out(), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (rsp_valid != 2'b00) bad++;
    end
    chk("t6_no_rsp", bad, 0);
    set_req(1, 1'b0, 2'd0, 16'h0050, 16'h0000);
    req_valid = 2'b11;
    wait_grant("t6_grant_after", 2'b01);
    req_valid = 2'b00;
    pready = 1'b1;
    for (int c = 0; c < 6; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dma_apb_master_arb.md
Name: dma_apb_master_arb

Overview:
- Round-robin arbiter and APB master sequencer for the DMA's APB control path.
- Accepts single-beat read/write requests from NUM_REQ requesters (DMA channels, CSR bridge).
- Runs the APB SETUP/ACCESS phases for the winning request and returns a response to that requester only.
- Drives the slave index, PSEL qualifier and PENABLE into the APB select/ready/rdata mux, and consumes its merged pready and prdata.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- APB_SVL, 4, number of APB slaves behind the mux.
- APB_ADDR_WIDTH, 16, APB address width.
- APB_DATA_WIDTH, 16, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles before an error response (>=2).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  NUM_REQ  per-requester request pending.
- i_req_write  input  NUM_REQ  1 = write, 0 = read.
- i_req_slv  input  [$clog2(APB_SVL)] x NUM_REQ  target slave index.
- i_req_addr  input  APB_ADDR_WIDTH x NUM_REQ  address.
- i_req_wdata  input  APB_DATA_WIDTH x NUM_REQ  write data.
- o_req_ready  output  NUM_REQ  one-hot accept pulse.
- o_rsp_valid  output  NUM_REQ  one-hot response pulse.
- o_rsp_rdata  output  APB_DATA_WIDTH  read data, shared by all requesters; qualified by o_rsp_valid.
- o_rsp_err  output  1  timeout or bad-slave error, qualified by o_rsp_valid.
- o_psel_idx  output  [$clog2(APB_SVL)]  slave index to the select mux.
- o_psel_vld  output  1  APB PSEL active (gates the decoded select).
- o_penable  output  1  APB PENABLE.
- o_pwrite  output  1  APB PWRITE.
- o_paddr  output  APB_ADDR_WIDTH  APB PADDR.
- o_pwdata  output  APB_DATA_WIDTH  APB PWDATA.
- i_pready  input  1  merged PREADY from the mux.
- i_prdata  input  APB_DATA_WIDTH  muxed PRDATA.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - All outputs are 0.
  - FSM goes to IDLE, the round-robin pointer goes to 0, and the timeout counter clears.
  - Reset mid-transfer abandons the transfer; no response is issued after reset release.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any i_req_valid is set, grant the first set bit searching from rr_ptr upward, with wrap.
  - In the same cycle: o_req_ready[winner]=1, latch write/slv/addr/wdata and the winner id, set rr_ptr = (winner+1) mod NUM_REQ.
  - If the latched slv >= APB_SVL (non-power-of-2 APB_SVL), go to RESP with err=1 and rdata=0, with no APB activity. Otherwise go to SETUP.
  - With no request, stay in IDLE with all APB outputs 0.
- SETUP (1 cycle):
  - o_psel_vld=1, o_penable=0.
  - paddr/pwdata/pwrite/psel_idx hold the latched values.
  - Clear the timeout counter, then go to ACCESS.
- ACCESS:
  - o_psel_vld=1, o_penable=1, address and control held stable.
  - Each cycle without i_pready increments the counter.
  - On i_pready=1: capture i_prdata (reads; writes capture 0), set err=0, go to RESP.
  - Else if the counter reaches TIMEOUT-1: set rdata=0, err=1, go to RESP. The transfer is abandoned.
  - i_pready and timeout in the same cycle: i_pready wins, no error.
- RESP (1 cycle):
  - o_psel_vld=0, o_penable=0.
  - o_rsp_valid[winner]=1 with o_rsp_rdata/o_rsp_err, then go to IDLE.
- Latency:
  - Accept at cycle T; SETUP at T+1; ACCESS at T+2.
  - Zero-wait slave gives the response at T+3. Minimum 4 cycles between accepts for one requester.
- Requester holding rules:
  - A requester keeps valid and payload stable until its o_req_ready.
  - A requester must not drop valid before accept; the arbiter ignores a dropped valid if it happens.
- A request re-asserted while its own response is pending is arbitrated normally in the next IDLE.
- o_req_ready and o_rsp_valid are never active for more than one requester.
- o_penable is never 1 without o_psel_vld.

Test Plan:
- Reset, then requester 0 reads slv 2 addr 0x0010, slave pready on the first ACCESS cycle with prdata 0xBEEF -> o_req_ready[0] at T, psel_vld T+1..T+2, penable T+2, o_rsp_valid[0] at T+3 with rdata 0xBEEF, err 0.
- Requester 1 writes 0x1234 to slv 1 addr 0x0004, 3 wait states -> paddr/pwdata/pwrite stable for all 4 ACCESS cycles; o_rsp_valid[1] with err 0 and rdata 0.
- Both requesters valid continuously for 4 transfers -> grants in order 0,1,0,1; never two ready bits set at once.
- TIMEOUT=16 and the slave never asserts pready -> exactly 16 ACCESS cycles, then o_rsp_valid with err 1 and rdata 0, then back to IDLE.
- Slave pready asserted on the timeout cycle -> err 0 with the captured prdata.
- i_rst_n pulsed low during ACCESS -> all outputs 0 immediately; after release no o_rsp_valid appears, and the next grant goes to requester 0.
